// File: rtl/ccs0001_jtag_tap.sv
// JTAG TAP for the ccs0001 core, clocked directly by CLK (acts as TCK).
// Provides IDCODE, BYPASS and a 32-bit JTAG-writable user configuration register.
module ccs0001_jtag_tap #(
  parameter int unsigned IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h0CC5_0001,
  parameter logic [31:0] USER_RST   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        PORESET,
  input  logic        tdi,
  input  logic        tms,
  output logic        tdo,
  output logic        tdo_oe,
  output logic [31:0] user_reg,
  output logic [3:0]  tap_state
);

  typedef enum logic [3:0] {
    StTlr     = 4'hF,
    StRti     = 4'hC,
    StSelDr   = 4'h7,
    StCapDr   = 4'h6,
    StShDr    = 4'h2,
    StEx1Dr   = 4'h1,
    StPauseDr = 4'h3,
    StEx2Dr   = 4'h0,
    StUpdDr   = 4'h5,
    StSelIr   = 4'h4,
    StCapIr   = 4'hE,
    StShIr    = 4'hA,
    StEx1Ir   = 4'h9,
    StPauseIr = 4'hB,
    StEx2Ir   = 4'h8,
    StUpdIr   = 4'hD
  } tap_state_e;

  localparam logic [IR_W-1:0] IrIdcode = IR_W'(1);
  localparam logic [IR_W-1:0] IrUser   = {1'b1, {(IR_W-1){1'b0}}};

  tap_state_e      state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]     dr_sr_q, dr_sr_d;
  logic [31:0]     user_q, user_d;
  logic            sel_idcode, sel_user;

  // Any code other than IDCODE or USER selects the 1-bit bypass path.
  assign sel_idcode = (ir_q == IrIdcode);
  assign sel_user   = (ir_q == IrUser);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:     state_d = tms ? StTlr     : StRti;
      StRti:     state_d = tms ? StSelDr   : StRti;
      StSelDr:   state_d = tms ? StSelIr   : StCapDr;
      StCapDr:   state_d = tms ? StEx1Dr   : StShDr;
      StShDr:    state_d = tms ? StEx1Dr   : StShDr;
      StEx1Dr:   state_d = tms ? StUpdDr   : StPauseDr;
      StPauseDr: state_d = tms ? StEx2Dr   : StPauseDr;
      StEx2Dr:   state_d = tms ? StUpdDr   : StShDr;
      StUpdDr:   state_d = tms ? StSelDr   : StRti;
      StSelIr:   state_d = tms ? StTlr     : StCapIr;
      StCapIr:   state_d = tms ? StEx1Ir   : StShIr;
      StShIr:    state_d = tms ? StEx1Ir   : StShIr;
      StEx1Ir:   state_d = tms ? StUpdIr   : StPauseIr;
      StPauseIr: state_d = tms ? StEx2Ir   : StPauseIr;
      StEx2Ir:   state_d = tms ? StUpdIr   : StShIr;
      StUpdIr:   state_d = tms ? StSelDr   : StRti;
      default:   state_d = StTlr;
    endcase
  end

  always_comb begin
    ir_d    = ir_q;
    ir_sr_d = ir_sr_q;
    dr_sr_d = dr_sr_q;
    user_d  = user_q;
    unique case (state_q)
      StTlr:   ir_d = IrIdcode;
      StCapIr: ir_sr_d = IrIdcode;
      StShIr:  ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
      StUpdIr: ir_d = ir_sr_q;
      StCapDr: begin
        if (sel_idcode)    dr_sr_d = IDCODE_VAL;
        else if (sel_user) dr_sr_d = user_q;
        else               dr_sr_d = 32'h0;
      end
      StShDr: begin
        if (sel_idcode || sel_user) dr_sr_d = {tdi, dr_sr_q[31:1]};
        else                        dr_sr_d[0] = tdi;
      end
      StUpdDr: begin
        if (sel_user) user_d = dr_sr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge PORESET) begin
    if (PORESET) begin
      state_q <= StTlr;
      ir_q    <= IrIdcode;
      ir_sr_q <= '0;
      dr_sr_q <= '0;
      user_q  <= USER_RST;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      dr_sr_q <= dr_sr_d;
      user_q  <= user_d;
    end
  end

  always_comb begin
    tdo    = 1'b0;
    tdo_oe = 1'b0;
    if (state_q == StShIr) begin
      tdo    = ir_sr_q[0];
      tdo_oe = 1'b1;
    end else if (state_q == StShDr) begin
      tdo    = dr_sr_q[0];
      tdo_oe = 1'b1;
    end
  end

  assign user_reg  = user_q;
  assign tap_state = state_q;

endmodule

// File: tb/tb_ccs0001_jtag_tap.sv
// Directed self-checking bench for ccs0001_jtag_tap: ID read, TLR recovery, IR scan,
// USER write/readback, BYPASS and reset mid-scan.
module tb_ccs0001_jtag_tap;

  logic        CLK = 1'b0;
  logic        PORESET = 1'b0;
  logic        tdi = 1'b0;
  logic        tms = 1'b1;
  logic        tdo, tdo_oe;
  logic [31:0] user_reg;
  logic [3:0]  tap_state;

  int errors = 0;
  int checks = 0;

  ccs0001_jtag_tap dut (
    .CLK       (CLK),
    .PORESET   (PORESET),
    .tdi       (tdi),
    .tms       (tms),
    .tdo       (tdo),
    .tdo_oe    (tdo_oe),
    .user_reg  (user_reg),
    .tap_state (tap_state)
  );

  always #5 CLK = ~CLK;

  // Drive inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge CLK);
    #1;
  endtask

  // From RTI: scan n bits of din through the DR, return tdo stream LSB-first, end in RTI.
  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout,
                         output logic oe_ok);
    dout  = '0;
    oe_ok = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (tdo_oe !== 1'b1) oe_ok = 1'b0;
      dout[i] = tdo;
      step(i == n - 1, din[i]);
    end
    if (tdo_oe !== 1'b0) oe_ok = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
    dout = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'hA) begin
      errors++;
      $display("FAIL ir_shift_state: got %h want a", tap_state);
    end
    for (int i = 0; i < 4; i++) begin
      dout[i] = tdo;
      step(i == 3, din[i]);
    end
    step(1'b1, 1'b0);
    checks++;
    if (tap_state !== 4'hD) begin
      errors++;
      $display("FAIL ir_update_state: got %h want d", tap_state);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    PORESET = 1'b1;
    #2;
    checks++;
    if (tap_state !== 4'hF || tdo !== 1'b0 || tdo_oe !== 1'b0 || user_reg !== 32'h0) begin
      errors++;
      $display("FAIL reset: state=%h tdo=%b oe=%b user=%h want f 0 0 00000000",
               tap_state, tdo, tdo_oe, user_reg);
    end
    @(negedge CLK);
    PORESET = 1'b0;
    step(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'hC) begin
      errors++;
      $display("FAIL reset_to_rti: got %h want c", tap_state);
    end
  endtask

  task automatic test_idcode();
    logic [31:0] d;
    logic ok;
    scan_dr(32, 32'h0, d, ok);
    checks++;
    if (d !== 32'h0CC5_0001) begin
      errors++;
      $display("FAIL idcode: got %h want 0cc50001", d);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idcode_oe: got 0 want 1 (oe only during shift)");
    end
  endtask

  task automatic test_ir_capture();
    logic [3:0] d;
    scan_ir(4'b1000, d);
    checks++;
    if (d !== 4'b0001) begin
      errors++;
      $display("FAIL ir_capture: got %b want 0001", d);
    end
  endtask

  task automatic test_tlr();
    logic [31:0] d;
    logic ok;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'h3) begin
      errors++;
      $display("FAIL pause_dr: got %h want 3", tap_state);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    checks++;
    if (tap_state !== 4'hF) begin
      errors++;
      $display("FAIL tlr: got %h want f", tap_state);
    end
    step(1'b0, 1'b0);
    // IR was USER before; an IDCODE readback shows TLR restored it.
    scan_dr(32, 32'h0, d, ok);
    checks++;
    if (d !== 32'h0CC5_0001) begin
      errors++;
      $display("FAIL tlr_ir_idcode: got %h want 0cc50001", d);
    end
  endtask

  task automatic test_user();
    logic [3:0] di;
    logic [31:0] d;
    logic ok;
    scan_ir(4'b1000, di);
    scan_dr(32, 32'hDEAD_BEEF, d, ok);
    checks++;
    if (user_reg !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL user_write: got %h want deadbeef", user_reg);
    end
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL user_first_read: got %h want 00000000", d);
    end
    scan_dr(32, 32'h0, d, ok);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL user_readback: got %h want deadbeef", d);
    end
    scan_dr(32, 32'hA5A5_5A5A, d, ok);
    checks++;
    if (user_reg !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL user_write2: got %h want a5a55a5a", user_reg);
    end
  endtask

  task automatic test_bypass(input logic [3:0] code);
    logic [3:0] di;
    logic [31:0] d;
    logic ok;
    scan_ir(code, di);
    // Pattern 1,0,1,1 in, expect 0,1,0,1 out.
    scan_dr(4, 32'hD, d, ok);
    checks++;
    if (d[3:0] !== 4'b1010) begin
      errors++;
      $display("FAIL bypass_%b: got %b want 1010", code, d[3:0]);
    end
    checks++;
    if (user_reg !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL bypass_user_%b: got %h want a5a55a5a", code, user_reg);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0] di;
    scan_ir(4'b1000, di);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
    checks++;
    if (tdo_oe !== 1'b1) begin
      errors++;
      $display("FAIL mid_scan_oe: got %b want 1", tdo_oe);
    end
    #2;
    PORESET = 1'b1;
    #1;
    checks++;
    if (user_reg !== 32'h0 || tap_state !== 4'hF || tdo !== 1'b0 || tdo_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: user=%h state=%h tdo=%b oe=%b want 00000000 f 0 0",
               user_reg, tap_state, tdo, tdo_oe);
    end
    @(negedge CLK);
    PORESET = 1'b0;
    step(1'b1, 1'b0);
    checks++;
    if (tap_state !== 4'hF) begin
      errors++;
      $display("FAIL post_reset_tlr: got %h want f", tap_state);
    end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_capture();
    test_tlr();
    test_user();
    test_bypass(4'b1111);
    test_bypass(4'b0101);
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
